// File: rtl/trng_bit_collector.sv
// trng_bit_collector: samples the selected RO, debiases it with von Neumann pairs, packs words and runs a repetition health test
module trng_bit_collector #(
  parameter int NUM_RO = 32,
  parameter int SEL_W = 5,
  parameter int WIDTH = 32,
  parameter int SAMPLE_DIV = 4,
  parameter int REP_LIMIT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ro_enable,
  input  logic [SEL_W-1:0] ctrl,
  input  logic [NUM_RO-1:0] ro_out,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             health_fail,
  output logic [7:0]       ovf_cnt
);
  localparam int P = 2 ** SEL_W;
  localparam int DW = SAMPLE_DIV > 1 ? $clog2(SAMPLE_DIV) : 1;
  localparam int RW = $clog2(REP_LIMIT + 1);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic {EMPTY, HALF} state_t;
  state_t state, state_n;
  logic [P-1:0] pad;
  logic s1, s2, first, prev, stb, trip, emit, done, load;
  logic [DW-1:0] div;
  logic [RW-1:0] rep, rep_n;
  logic [CW-1:0] cnt;
  logic [WIDTH-2:0] acc;
  logic [WIDTH-1:0] word;
  // zero-extending the RO bus makes out-of-range selects read 0
  always_comb begin
    pad = P'(ro_out);
    stb = ro_enable && div == DW'(SAMPLE_DIV - 1);
    rep_n = (rep != '0 && s2 == prev) ? (rep == RW'(REP_LIMIT) ? rep : rep + 1'b1) : RW'(1);
    trip = stb && rep_n == RW'(REP_LIMIT);
    word = {acc, first};
    done = emit && cnt == CW'(WIDTH - 1);
    load = done && (!data_valid || data_ready);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= EMPTY;
    else state <= state_n;
  always_comb
    state_n = !ro_enable ? EMPTY : stb ? (state == EMPTY ? HALF : EMPTY) : state;
  always_comb
    emit = stb && state == HALF && first != s2 && !health_fail && !trip;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      div <= '0;
      rep <= '0;
      prev <= 1'b0;
      first <= 1'b0;
      acc <= '0;
      cnt <= '0;
      data_out <= '0;
      data_valid <= 1'b0;
      health_fail <= 1'b0;
      ovf_cnt <= 8'd0;
    end else begin
      s1 <= pad[ctrl];
      s2 <= s1;
      div <= (!ro_enable || stb) ? '0 : div + 1'b1;
      rep <= !ro_enable ? '0 : stb ? rep_n : rep;
      if (stb) prev <= s2;
      if (stb && state == EMPTY) first <= s2;
      health_fail <= health_fail | trip;
      if (done) begin
        acc <= '0;
        cnt <= '0;
      end else if (emit) begin
        acc <= word[WIDTH-2:0];
        cnt <= cnt + 1'b1;
      end
      if (load) data_out <= word;
      data_valid <= load | (data_valid & ~data_ready);
      if (done && !load && ovf_cnt != 8'hFF) ovf_cnt <= ovf_cnt + 1'b1;
    end
endmodule

// File: tb/tb_trng_bit_collector.sv
// tb_trng_bit_collector: directed and random stimulus on two configurations checked against a behavioural model
module tb_trng_bit_collector;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, rdy = 1'b0;
  logic [4:0] ctrl = '0;
  logic [19:0] ro = '0;
  logic [7:0] do_a, do_b, ov_a, ov_b;
  logic dv_a, dv_b, hf_a, hf_b;
  int nchk = 0, nerr = 0;
  int DIV[2] = '{1, 4};
  int LIM[2] = '{64, 16};
  int cyc[2], run[2], wacc[2], wn[2], ovf[2];
  bit s1m[2], s2m[2], half[2], first[2], havep[2], prevm[2], fail[2], dv[2];
  logic [7:0] dout[2];
  bit q[$];
  logic [19:0] pat;
  always #5 clk = ~clk;
  trng_bit_collector #(.NUM_RO(20), .SEL_W(5), .WIDTH(8), .SAMPLE_DIV(1), .REP_LIMIT(64)) dut_a (
    .clk(clk), .rst(rst), .ro_enable(en), .ctrl(ctrl), .ro_out(ro), .data_out(do_a),
    .data_valid(dv_a), .data_ready(rdy), .health_fail(hf_a), .ovf_cnt(ov_a));
  trng_bit_collector #(.NUM_RO(20), .SEL_W(5), .WIDTH(8), .SAMPLE_DIV(4), .REP_LIMIT(16)) dut_b (
    .clk(clk), .rst(rst), .ro_enable(en), .ctrl(ctrl), .ro_out(ro), .data_out(do_b),
    .data_valid(dv_b), .data_ready(rdy), .health_fail(hf_b), .ovf_cnt(ov_b));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      cyc[k] = 0; run[k] = 0; wacc[k] = 0; wn[k] = 0; ovf[k] = 0;
      s1m[k] = 0; s2m[k] = 0; half[k] = 0; first[k] = 0; havep[k] = 0;
      prevm[k] = 0; fail[k] = 0; dv[k] = 0; dout[k] = '0;
    end
  endtask
  // one clock of the reference: samples, strobes, pairs, words, handoff
  task automatic model_update();
    bit selv, smp, stb, emit, done, ld;
    selv = (ctrl < 5'd20) ? ro[ctrl] : 1'b0;
    for (int k = 0; k < 2; k++) begin
      smp = s2m[k];
      stb = en && (cyc[k] % DIV[k] == DIV[k] - 1);
      s2m[k] = s1m[k];
      s1m[k] = selv;
      if (!en) begin
        cyc[k] = 0; half[k] = 0; havep[k] = 0;
      end else begin
        cyc[k]++;
        if (stb) begin
          run[k] = (havep[k] && smp == prevm[k]) ? run[k] + 1 : 1;
          havep[k] = 1;
          prevm[k] = smp;
          emit = half[k] && first[k] != smp && !fail[k] && run[k] < LIM[k];
          if (run[k] >= LIM[k]) fail[k] = 1;
          if (!half[k]) first[k] = smp;
          half[k] = !half[k];
          if (emit) begin
            wacc[k] = wacc[k] * 2 + int'(first[k]);
            wn[k]++;
          end
        end
      end
      done = wn[k] == 8;
      ld = done && (!dv[k] || rdy);
      if (ld) dout[k] = 8'(wacc[k]);
      else if (done && ovf[k] < 255) ovf[k]++;
      if (done) begin
        wacc[k] = 0; wn[k] = 0;
      end
      if (ld) dv[k] = 1;
      else if (dv[k] && rdy) dv[k] = 0;
    end
  endtask
  task automatic check_all();
    chk("a_data", do_a, dout[0]);
    chk("a_valid", dv_a, dv[0]);
    chk("a_health", hf_a, fail[0]);
    chk("a_ovf", ov_a, ovf[0]);
    chk("b_data", do_b, dout[1]);
    chk("b_valid", dv_b, dv[1]);
    chk("b_health", hf_b, fail[1]);
    chk("b_ovf", ov_b, ovf[1]);
  endtask
  task automatic step();
    @(posedge clk);
    if (rst) model_update();
    #1;
    check_all();
  endtask
  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    step();
    rst = 1'b1;
  endtask
  task automatic add_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) begin
      q.push_back(w[i]);
      q.push_back(!w[i]);
    end
  endtask
  // enable is held low two cycles so strobes line up with the sync delay
  task automatic drive_seq(input bit b[$], input bit rl);
    int n = b.size();
    for (int j = 0; j < n + 2; j++) begin
      en = j >= 2;
      rdy = (j == n + 1) ? rl : 1'b0;
      ctrl = 5'($urandom_range(0, 19));
      ro = 20'($urandom);
      ro[ctrl] = (j < n) ? b[j] : 1'($urandom_range(0, 1));
      step();
    end
    en = 1'b0;
    rdy = 1'b0;
  endtask
  initial begin
    model_reset();
    #2 rst = 1'b0;
    #1 check_all();
    step();
    rst = 1'b1;
    q.delete();
    pat = 20'b10010010101101011001;
    for (int i = 19; i >= 0; i--) q.push_back(pat[i]);
    drive_seq(q, 1'b0);
    chk("debias_word", do_a, 8'hB2);
    chk("debias_valid", dv_a, 1'b1);
    q.delete();
    add_word(8'hFF);
    drive_seq(q, 1'b0);
    chk("bp_hold", do_a, 8'hB2);
    chk("bp_ovf", ov_a, 8'd1);
    rdy = 1'b1;
    step();
    rdy = 1'b0;
    chk("bp_pop", dv_a, 1'b0);
    do_reset();
    q.delete();
    add_word(8'h3C);
    drive_seq(q, 1'b0);
    chk("col_w1", do_a, 8'h3C);
    q.delete();
    add_word(8'hA5);
    drive_seq(q, 1'b1);
    chk("col_w2", do_a, 8'hA5);
    chk("col_valid", dv_a, 1'b1);
    chk("col_ovf", ov_a, 8'd0);
    do_reset();
    q.delete();
    add_word(8'h69);
    drive_seq(q, 1'b0);
    q.delete();
    repeat (63) q.push_back(1'b1);
    drive_seq(q, 1'b0);
    chk("hf_63", hf_a, 1'b0);
    q.push_back(1'b1);
    drive_seq(q, 1'b0);
    chk("hf_64", hf_a, 1'b1);
    q.delete();
    repeat (16) begin
      q.push_back(1'b0);
      q.push_back(1'b1);
    end
    drive_seq(q, 1'b0);
    chk("hf_sticky", hf_a, 1'b1);
    chk("hf_word", do_a, 8'h69);
    chk("hf_noemit", ov_a, 8'd0);
    rdy = 1'b1;
    step();
    rdy = 1'b0;
    chk("hf_pop", dv_a, 1'b0);
    do_reset();
    q.delete();
    q.push_back(1'b0);
    drive_seq(q, 1'b0);
    q.delete();
    add_word(8'h80);
    drive_seq(q, 1'b0);
    chk("en_drop_word", do_a, 8'h80);
    do_reset();
    q.delete();
    repeat (4) add_word(8'hFF);
    drive_seq(q, 1'b0);
    chk("ar_pre_ovf", ov_a, 8'd3);
    chk("ar_pre_valid", dv_a, 1'b1);
    #3 rst = 1'b0;
    model_reset();
    #1;
    chk("ar_data", do_a, 8'd0);
    chk("ar_valid", dv_a, 1'b0);
    chk("ar_ovf", ov_a, 8'd0);
    chk("ar_health", hf_a, 1'b0);
    step();
    step();
    rst = 1'b1;
    q.delete();
    repeat (258) add_word(8'hC3);
    drive_seq(q, 1'b0);
    chk("ovf_sat", ov_a, 8'd255);
    chk("ovf_sat_word", do_a, 8'hC3);
    do_reset();
    repeat (3000) begin
      en = $urandom_range(0, 15) != 0;
      rdy = 1'($urandom_range(0, 1));
      ctrl = 5'($urandom);
      ro = 20'($urandom);
      step();
    end
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule

// File: doc/trng_bit_collector.md
# trng_bit_collector

Downstream stage of the ring-oscillator controller in the RO-TRNG. Samples the ring oscillator output currently selected by the controller's `ctrl` index, synchronizes it, removes bias with a von Neumann corrector, and packs the debiased bits into words delivered over a valid/ready interface. It also runs a repetition-count health test and counts words lost to backpressure.

## Interface

Parameters:
- `NUM_RO`, 32: number of ring oscillator outputs on `ro_out`.
- `SEL_W`, 5: width of `ctrl`; 2^SEL_W must be ≥ NUM_RO.
- `WIDTH`, 32: output word width in bits, ≥ 2.
- `SAMPLE_DIV`, 4: clocks per sample strobe, ≥ 1.
- `REP_LIMIT`, 64: consecutive identical raw samples that trip the health test, ≥ 2.

Ports:
- `clk`, input, 1: system clock; all state on rising edge.
- `rst`, input, 1: reset; asynchronous assert, active-low.
- `ro_enable`, input, 1: same enable the controller uses; collection runs only while high.
- `ctrl`, input, SEL_W: RO select index from the controller.
- `ro_out`, input, NUM_RO: raw, asynchronous RO outputs.
- `data_out`, output, WIDTH: collected random word.
- `data_valid`, output, 1: `data_out` holds an unconsumed word.
- `data_ready`, input, 1: consumer accepts the word when high with `data_valid`.
- `health_fail`, output, 1: sticky repetition-test failure.
- `ovf_cnt`, output, 8: saturating count of dropped words.

## Operation

- Reset (`rst` low): all outputs and internal state go to 0 immediately; `data_out`=0, `data_valid`=0, `health_fail`=0, `ovf_cnt`=0.
- Sync: `ro_out[ctrl]` is muxed, then passed through two flops (`s1`, `s2`). If `ctrl` ≥ NUM_RO, the mux selects 0.
- Strobe: a divider counts 0..SAMPLE_DIV-1 while `ro_enable`=1. The strobe fires in the cycle the count equals SAMPLE_DIV-1, then the count wraps to 0. Raw sample = `s2` at the strobe.
- Pair FSM has two states, EMPTY and HALF. Transitions occur on strobes only.
  - EMPTY → HALF: store the sample as `first`.
  - HALF → EMPTY: with the second sample, pair 01 emits bit 0 and pair 10 emits bit 1. Pairs 00 and 11 are discarded.
- Packing: an emitted bit shifts into bit 0 of an accumulator, and the older bits move left. The first bit of a word ends up at the MSB. A word is complete when the bit counter reaches WIDTH.
- Word handoff on completion:
  - If `data_valid`=0, or `data_ready`=1 in the same cycle, load the word into `data_out` with `data_valid`=1.
  - Otherwise drop the word and increment `ovf_cnt`, saturating at 255.
  - In both cases the accumulator and bit counter restart at 0.
- Pop: `data_valid`∧`data_ready` with no simultaneous load clears `data_valid`. `data_out` keeps its value.
- Health test:
  - The repetition counter is set to 1 on the first strobe after reset.
  - Each strobe increments it if the sample equals the previous sample, else resets it to 1.
  - When it reaches REP_LIMIT, `health_fail` is set and stays at 1 until reset.
  - While `health_fail`=1, no bits are emitted. A word already in `data_out` remains poppable.
- `ro_enable` low: the divider goes to 0, the pair FSM goes to EMPTY (any half pair is discarded), and the repetition counter goes to 0. The accumulator, bit counter, output register and flags are retained. The sync flops keep sampling.

## Timing

- Raw sample path: `ro_out` change → `s1` at edge k → `s2` at k+1. The earliest strobe that uses it is at k+2.
- First strobe: SAMPLE_DIV cycles after `ro_enable` rises, counted from that edge.
- Latency: a strobe completing the WIDTH-th bit drives `data_valid` high at the next rising edge.
- Handshake: `data_out` is stable while `data_valid`=1 and not popped. No combinational path from `data_ready` to `data_valid`.
- Simultaneous pop and load: the new word appears the next cycle, `data_valid` stays 1, and `ovf_cnt` is unchanged.
- Simultaneous health trip and bit emission on the same strobe: the bit is not emitted.
- `ovf_cnt` at 255 plus another drop: stays 255.

## Test plan

- Async reset mid-operation: drive `rst` low between clock edges while `data_valid`=1 and `ovf_cnt`=3. Required: all outputs read 0 before the next edge, and stay 0 until `rst` returns high.
- Debias and pack (WIDTH=8, SAMPLE_DIV=1): drive raw pairs 10,01,00,10,10,11,01,01,10,01. Required: `data_out`=8'hB2 and `data_valid`=1 one cycle after the last strobe. The 00 and 11 pairs contribute no bits.
- Backpressure: hold `data_ready`=0 and complete two words. Required: the first word is held, `ovf_cnt`=1, and after `data_ready`=1 for one cycle `data_valid`=0.
- Pop/load collision: assert `data_ready`=1 on the exact completion cycle of word 2. Required: `data_out` changes to word 2, `data_valid` has no low cycle, and `ovf_cnt`=0.
- Health trip (REP_LIMIT=64): hold the selected RO at 1 for 64 strobes. Required: `health_fail`=1 after strobe 64. Later alternating 0/1 input leaves it at 1, emits no bits, and a pending word is still popped normally.
- Enable drop mid-pair: lower `ro_enable` in state HALF, then raise it and drive pair 10. Required: the first bit emitted is 1, and the stale half sample is never paired.
